dmem_mmio_responder: RTL and testbench

//  Responder on the processor's dmem port (address_dmem/data/wren/q_dmem). Forwards RAM accesses
//  to the dmem syncram; serves a 16-word MMIO window (cycle counter, scratch, TX FIFO, status).

---
 rtl/dmem_mmio_responder_pkg.sv | 19 +
 rtl/dmem_mmio_responder_if.sv | 28 ++
 rtl/dmem_mmio_responder_tx_fifo.sv | 50 +++++
 rtl/dmem_mmio_responder.sv | 109 ++++++++++
 tb/tb_dmem_mmio_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the dmem MMIO responder: register offsets inside the
// 16-word window, STATUS bit positions and the window offset width.
package dmem_mmio_responder_pkg;

    // Low address bits that select a register inside the MMIO window;
    // the remaining upper bits must match the window base.
    localparam int WIN_OFF_W = 4;

    localparam logic [WIN_OFF_W-1:0] OFF_CYCLE   = 4'd0;
    localparam logic [WIN_OFF_W-1:0] OFF_SCRATCH = 4'd1;
    localparam logic [WIN_OFF_W-1:0] OFF_TX      = 4'd2;
    localparam logic [WIN_OFF_W-1:0] OFF_STATUS  = 4'd3;

    // STATUS layout: [3:0] FIFO count, then flags.
    localparam int ST_EMPTY = 4;
    localparam int ST_FULL  = 5;
    localparam int ST_OVF   = 6;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Processor dmem port, syncram side-channel and TX drain handshake,
// bundled so the responder sits between processor and RAM with one port.
interface dmem_mmio_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address_dmem;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic [DATA_WIDTH-1:0] q_dmem;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    // Responder view.
    modport slave (
        input  address_dmem, data, wren, ram_q, tx_ready,
        output q_dmem, ram_wren, tx_data, tx_valid
    );

    // Processor / syncram / consumer view.
    modport master (
        output address_dmem, data, wren, ram_q, tx_ready,
        input  q_dmem, ram_wren, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Synchronous TX FIFO. A push while full is only accepted when a pop frees
// a slot in the same cycle; a pop while empty is ignored.
module dmem_mmio_responder_tx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PTR_W-1:0]                 wr_ptr;
    logic [PTR_W-1:0]                 rd_ptr;
    logic [CNT_W-1:0]                 count_q;
    logic                             do_push;
    logic                             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage needs no reset; contents are don't-care while empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem port responder: passes RAM accesses to the syncram and serves a
// 16-word MMIO window (cycle counter, scratch, TX FIFO, status). Read data
// has one cycle of latency to line up with the syncram.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hFF0,
    parameter int                    FIFO_DEPTH = 8
) (
    input logic                  clock,
    input logic                  reset,
    dmem_mmio_responder_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  in_mmio;
    logic [WIN_OFF_W-1:0]  offset;
    logic                  mmio_wr;
    logic                  push;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] cycle_q;
    logic [DATA_WIDTH-1:0] scratch_q;
    logic                  ovf_q;
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  in_mmio_q;
    logic [DATA_WIDTH-1:0] mmio_rdata_q;

    assign in_mmio      = (bus.address_dmem[ADDR_WIDTH-1:WIN_OFF_W] == MMIO_BASE[ADDR_WIDTH-1:WIN_OFF_W]);
    assign offset       = bus.address_dmem[WIN_OFF_W-1:0];
    assign mmio_wr      = bus.wren & in_mmio;
    assign bus.ram_wren = bus.wren & ~in_mmio;
    assign push         = mmio_wr && (offset == OFF_TX);
    assign bus.tx_valid = ~fifo_empty;

    dmem_mmio_responder_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (bus.tx_ready),
        .wdata (bus.data),
        .rdata (bus.tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Free-running cycle counter; a CYCLE write takes priority over the increment.
    always_ff @(posedge clock) begin
        if (!reset)                                cycle_q <= '0;
        else if (mmio_wr && (offset == OFF_CYCLE)) cycle_q <= bus.data;
        else                                       cycle_q <= cycle_q + DATA_WIDTH'(1);
    end

    // Scratch register.
    always_ff @(posedge clock) begin
        if (!reset)                                  scratch_q <= '0;
        else if (mmio_wr && (offset == OFF_SCRATCH)) scratch_q <= bus.data;
    end

    // Sticky overflow: set when a push is dropped (full and nothing draining
    // this cycle), cleared by any STATUS write.
    always_ff @(posedge clock) begin
        if (!reset)                                 ovf_q <= 1'b0;
        else if (mmio_wr && (offset == OFF_STATUS)) ovf_q <= 1'b0;
        else if (push && fifo_full && !bus.tx_ready) ovf_q <= 1'b1;
    end

    // STATUS word built from pre-edge FIFO state.
    always_comb begin
        status              = '0;
        status[CNT_W-1:0]   = fifo_count;
        status[ST_EMPTY]    = fifo_empty;
        status[ST_FULL]     = fifo_full;
        status[ST_OVF]      = ovf_q;
    end

    // MMIO read mux; TX and unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CYCLE:   rdata = cycle_q;
            OFF_SCRATCH: rdata = scratch_q;
            OFF_STATUS:  rdata = status;
            default:     rdata = '0;
        endcase
    end

    // One-cycle read pipeline matching syncram latency; reset selects the
    // MMIO path with zero data so q_dmem is clean out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            in_mmio_q    <= 1'b1;
            mmio_rdata_q <= '0;
        end else begin
            in_mmio_q    <= in_mmio;
            mmio_rdata_q <= rdata;
        end
    end

    assign bus.q_dmem = in_mmio_q ? mmio_rdata_q : bus.ram_q;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a behavioural syncram.
module tb_dmem_mmio_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dmem_mmio_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus();

    dmem_mmio_responder #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .MMIO_BASE  (12'hFF0),
        .FIFO_DEPTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Syncram: one-cycle read latency, write-first not required.
    logic [31:0] ram [0:4095];
    always @(posedge clock) begin
        if (bus.ram_wren) ram[bus.address_dmem] <= bus.data;
        bus.ram_q <= ram[bus.address_dmem];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w);
        bus.address_dmem = a;
        bus.data         = d;
        bus.wren         = w;
    endtask

    task automatic test_reset();
        drive(12'h000, 32'h0, 1'b0);
        bus.tx_ready = 1'b0;
        reset = 1'b0;
        repeat (2) cyc();
        checks++;
        if (bus.q_dmem !== 32'h0) begin
            errors++; $display("FAIL reset_q: got %h want %h", bus.q_dmem, 32'h0);
        end
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid);
        end
    endtask

    task automatic test_cycle_after_reset();
        reset = 1'b1;
        repeat (4) cyc();
        drive(12'hFF0, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'd4) begin
            errors++; $display("FAIL t1_cycle: got %h want %h", bus.q_dmem, 32'd4);
        end
        drive(12'hFF3, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h10) begin
            errors++; $display("FAIL t1_status: got %h want %h", bus.q_dmem, 32'h10);
        end
    endtask

    task automatic test_ram_and_scratch();
        drive(12'h010, 32'h123, 1'b1);
        #1;
        checks++;
        if (bus.ram_wren !== 1'b1) begin
            errors++; $display("FAIL t2_ram_wren: got %b want 1", bus.ram_wren);
        end
        cyc();
        drive(12'h010, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h123) begin
            errors++; $display("FAIL t2_ram_read: got %h want %h", bus.q_dmem, 32'h123);
        end
        // Just below the window still goes to RAM.
        drive(12'hFEF, 32'h77, 1'b1);
        #1;
        checks++;
        if (bus.ram_wren !== 1'b1) begin
            errors++; $display("FAIL t2_edge_wren: got %b want 1", bus.ram_wren);
        end
        cyc();
        drive(12'hFEF, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h77) begin
            errors++; $display("FAIL t2_edge_read: got %h want %h", bus.q_dmem, 32'h77);
        end
        drive(12'hFF1, 32'hDEADBEEF, 1'b1);
        #1;
        checks++;
        if (bus.ram_wren !== 1'b0) begin
            errors++; $display("FAIL t2_scratch_wren: got %b want 0", bus.ram_wren);
        end
        cyc();
        drive(12'hFF1, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'hDEADBEEF) begin
            errors++; $display("FAIL t2_scratch_read: got %h want %h", bus.q_dmem, 32'hDEADBEEF);
        end
        // Unmapped offset: write ignored, reads zero.
        drive(12'hFF7, 32'h5A5A5A5A, 1'b1);
        #1;
        checks++;
        if (bus.ram_wren !== 1'b0) begin
            errors++; $display("FAIL t2_unmapped_wren: got %b want 0", bus.ram_wren);
        end
        cyc();
        drive(12'hFF7, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h0) begin
            errors++; $display("FAIL t2_unmapped_read: got %h want %h", bus.q_dmem, 32'h0);
        end
    endtask

    task automatic test_fifo_overflow();
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            drive(12'hFF2, 32'(i), 1'b1);
            cyc();
        end
        drive(12'hFF3, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h68) begin
            errors++; $display("FAIL t3_status_full_ovf: got %h want %h", bus.q_dmem, 32'h68);
        end
        drive(12'hFF3, 32'h0, 1'b1);
        cyc();
        drive(12'hFF3, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h28) begin
            errors++; $display("FAIL t3_status_cleared: got %h want %h", bus.q_dmem, 32'h28);
        end
        // Head must be 1 and hold while not ready.
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'd1) begin
            errors++; $display("FAIL t3_head_hold: got v=%b d=%h want v=1 d=%h", bus.tx_valid, bus.tx_data, 32'd1);
        end
        bus.tx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'(k)) begin
                errors++; $display("FAIL t3_drain: got v=%b d=%h want v=1 d=%h", bus.tx_valid, bus.tx_data, 32'(k));
            end
            cyc();
        end
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL t3_drained_empty: got %b want 0", bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp [0:7];
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(12'hFF2, 32'h10 + 32'(i), 1'b1);
            cyc();
        end
        // Full, push and pop in the same cycle.
        drive(12'hFF2, 32'hAA, 1'b1);
        bus.tx_ready = 1'b1;
        cyc();
        bus.tx_ready = 1'b0;
        drive(12'hFF3, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h28) begin
            errors++; $display("FAIL t4_status: got %h want %h", bus.q_dmem, 32'h28);
        end
        for (int i = 0; i < 7; i++) exp[i] = 32'h11 + 32'(i);
        exp[7] = 32'hAA;
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[k]) begin
                errors++; $display("FAIL t4_drain: got v=%b d=%h want v=1 d=%h", bus.tx_valid, bus.tx_data, exp[k]);
            end
            cyc();
        end
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL t4_drained_empty: got %b want 0", bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_cycle_wrap();
        logic [31:0] exp [0:2];
        exp[0] = 32'hFFFFFFFE;
        exp[1] = 32'hFFFFFFFF;
        exp[2] = 32'h0;
        drive(12'hFF0, 32'hFFFFFFFE, 1'b1);
        cyc();
        drive(12'hFF0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (bus.q_dmem !== exp[k]) begin
                errors++; $display("FAIL t5_wrap: got %h want %h", bus.q_dmem, exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid_traffic();
        bus.tx_ready = 1'b0;
        drive(12'hFF2, 32'h55, 1'b1);
        cyc();
        drive(12'hFF0, 32'h0, 1'b0);
        checks++;
        if (bus.tx_valid !== 1'b1) begin
            errors++; $display("FAIL t6_pre_valid: got %b want 1", bus.tx_valid);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL t6_tx_valid: got %b want 0", bus.tx_valid);
        end
        checks++;
        if (bus.q_dmem !== 32'h0) begin
            errors++; $display("FAIL t6_q_reset: got %h want %h", bus.q_dmem, 32'h0);
        end
        reset = 1'b1;
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h0) begin
            errors++; $display("FAIL t6_first_cycle: got %h want %h", bus.q_dmem, 32'h0);
        end
        drive(12'hFF3, 32'h0, 1'b0);
        cyc();
        checks++;
        if (bus.q_dmem !== 32'h10) begin
            errors++; $display("FAIL t6_status: got %h want %h", bus.q_dmem, 32'h10);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        test_reset();
        test_cycle_after_reset();
        test_ram_and_scratch();
        test_fifo_overflow();
        test_push_pop_full();
        test_cycle_wrap();
        test_reset_mid_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
